iq_decoder: RTL and testbench

//  Write-side front end of instruction_queue. Accepts a stream of 32-bit instruction words on a

---
 rtl/iq_decoder.sv | 134 +++++++++++++
 tb/tb_iq_decoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_decoder.sv
// Unpacks 32-bit instruction words (plus optional ADDR_LO/ADDR_HI words) onto the queue field bus; 1-cycle latency.
// Stall freezes the bus and holds word_ready low when the output slot is busy; ILLEGAL_CHECK_EN enables malformed-instruction drop + err.
`timescale 1ns/1ps
module iq_decoder #(
  parameter int ADDR_W  = 48,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        word_in,
  input  logic               word_valid,
  output logic               word_ready,
  input  logic               stall,
  output logic               out_valid,
  output logic [3:0]         MajorOpcode,
  output logic [4:0]         Source1,
  output logic [4:0]         Source2,
  output logic [1:0]         OffsetScale,
  output logic [4:0]         Destination,
  output logic [3:0]         MinorOpcode,
  output logic               HasAddress,
  output logic               OffsetSub,
  output logic [ADDR_W-1:0]  Address,
  output logic [COUNT_W-1:0] instr_count,
  output logic               err
);

  typedef enum logic [1:0] {S_OP, S_ALO, S_AHI} state_t;

  state_t              state, state_nxt;
  logic [26:0]         op_q;
  logic [31:0]         lo_q;
  logic [26:0]         bus_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [63:0]         full_addr;
  logic [26:0]         fields_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                drain, out_free, acc, final_acc, load, ill_final;
  logic                unused_bits;

  assign drain      = out_valid && !stall;
  assign out_free   = !out_valid || drain;
  // The ADDR_LO slot never touches the output register, so it is always open.
  assign word_ready = (state == S_ALO) || out_free;
  assign acc        = word_valid && word_ready;
  assign full_addr  = {word_in, lo_q};
  assign unused_bits = ^full_addr;

  always_comb begin
    state_nxt  = state;
    final_acc  = 1'b0;
    fields_nxt = op_q;
    addr_nxt   = full_addr[ADDR_W-1:0];
    case (state)
      S_OP: begin
        fields_nxt = word_in[31:5];
        addr_nxt   = '0;
        if (acc) begin
          if (word_in[6]) state_nxt = S_ALO;
          else            final_acc = 1'b1;
        end
      end
      S_ALO: if (acc) state_nxt = S_AHI;
      S_AHI: begin
        if (acc) begin
          state_nxt = S_OP;
          final_acc = 1'b1;
        end
      end
      default: state_nxt = S_OP;
    endcase
  end

  assign load = final_acc && !ill_final;

`ifdef ILLEGAL_CHECK_EN
  logic        ill_q;
  logic        ill_op;
  logic [31:0] hi_excess;

  assign ill_op    = word_in[4:0] != 5'd0;
  assign hi_excess = word_in >> (ADDR_W - 32);
  assign ill_final = (state == S_OP) ? ill_op : (ill_q || (hi_excess != 32'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_q <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (acc && state == S_OP) ill_q <= ill_op;
      err <= final_acc && ill_final;
    end
  end
`else
  assign ill_final = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_OP;
      op_q        <= '0;
      lo_q        <= '0;
      bus_q       <= '0;
      addr_q      <= '0;
      out_valid   <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (acc && state == S_OP)  op_q <= word_in[31:5];
      if (acc && state == S_ALO) lo_q <= word_in;
      // A load in the drain cycle keeps out_valid high: no bubble between instructions.
      if (load) begin
        bus_q     <= fields_nxt;
        addr_q    <= addr_nxt;
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (drain) instr_count <= instr_count + 1'b1;
    end
  end

  assign MajorOpcode = bus_q[26:23];
  assign Source1     = bus_q[22:18];
  assign Source2     = bus_q[17:13];
  assign OffsetScale = bus_q[12:11];
  assign Destination = bus_q[10:6];
  assign MinorOpcode = bus_q[5:2];
  assign HasAddress  = bus_q[1];
  assign OffsetSub   = bus_q[0];
  assign Address     = addr_q;

endmodule

// File: tb/tb_iq_decoder.sv
// Randomized self-checking bench for iq_decoder: instruction-level scoreboard plus directed corner cases.
`timescale 1ns/1ps
module tb_iq_decoder;
  localparam int AW = 48;
  localparam int CW = 4;

  typedef logic [80:0] bus_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   word_in;
  logic          word_valid;
  logic          word_ready;
  logic          stall;
  logic          out_valid;
  logic [3:0]    MajorOpcode, MinorOpcode;
  logic [4:0]    Source1, Source2, Destination;
  logic [1:0]    OffsetScale;
  logic          HasAddress, OffsetSub;
  logic [AW-1:0] Address;
  logic [CW-1:0] instr_count;
  logic          err;

  iq_decoder #(.ADDR_W(AW), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .stall(stall), .out_valid(out_valid),
    .MajorOpcode(MajorOpcode), .Source1(Source1), .Source2(Source2),
    .OffsetScale(OffsetScale), .Destination(Destination), .MinorOpcode(MinorOpcode),
    .HasAddress(HasAddress), .OffsetSub(OffsetSub), .Address(Address),
    .instr_count(instr_count), .err(err)
  );

  always #5 clk = ~clk;

  bus_t          exp_q[$];
  bus_t          dut_bus;
  bus_t          prev_bus;
  logic [CW-1:0] exp_cnt = '0;
  int            n_chk = 0, n_fail = 0;
  int            err_exp = 0, err_seen = 0;
  int            run = 0, max_run = 0;
  bit            prev_hold = 1'b0;
  bit            stall_rand = 1'b0;

  assign dut_bus = {MajorOpcode, Source1, Source2, OffsetScale, Destination,
                    MinorOpcode, HasAddress, OffsetSub, Address};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bus_t make_exp(input logic [31:0] op, input logic [31:0] lo, input logic [31:0] hi);
    logic [63:0]   full;
    logic [AW-1:0] a;
    full = {hi, lo};
    a    = op[6] ? full[AW-1:0] : '0;
    return {op[31:28], op[27:23], op[22:18], op[17:16], op[15:11], op[10:7], op[6], op[5], a};
  endfunction

  function automatic bit is_illegal(input logic [31:0] op, input logic [31:0] hi);
`ifdef ILLEGAL_CHECK_EN
    return (op[4:0] != 5'd0) || (op[6] && ((hi >> (AW - 32)) != 32'd0));
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard: every drain must deliver the oldest expected instruction.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
      run = 0;
    end else begin
      check("instr_count", instr_count, exp_cnt);
      if (prev_hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_bus", dut_bus, prev_bus);
      end
      if (out_valid && !stall) begin
        if (exp_q.size() == 0) check("spurious_valid", out_valid, 1'b0);
        else                   check("bus", dut_bus, exp_q.pop_front());
        exp_cnt = exp_cnt + 1'b1;
      end
      run = out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (err) err_seen++;
      prev_hold = out_valid && stall;
      prev_bus  = dut_bus;
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (stall_rand) stall = ($urandom_range(0, 2) == 0);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    word_valid = 1'b0;
    word_in = '0;
    stall = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_count", instr_count, 0);
    check("rst_err", err, 1'b0);
    check("rst_bus", dut_bus, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int n = 0;
    bit r;
    repeat (gap) begin
      @(posedge clk);
      #2;
    end
    word_in = w;
    word_valid = 1'b1;
    forever begin
      @(negedge clk);
      r = word_ready;
      @(posedge clk);
      #2;
      if (r) break;
      n++;
      if (n > 300) begin
        check("ready_timeout", r, 1'b1);
        break;
      end
    end
    word_valid = 1'b0;
  endtask

  task automatic send_instr(input logic [31:0] op, input logic [31:0] lo, input logic [31:0] hi, input int gap);
    send_word(op, gap);
    if (op[6]) begin
      send_word(lo, gap);
      send_word(hi, gap);
    end
    if (is_illegal(op, hi)) err_exp++;
    else exp_q.push_back(make_exp(op, lo, hi));
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
      n++;
      if (n > 500) begin
        check("idle_timeout", exp_q.size(), 0);
        break;
      end
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    word_valid = 1'b0;
    word_in = '0;
    stall = 1'b0;
    do_reset();

    // Back-to-back address-free instructions leave no gaps on out_valid.
    max_run = 0;
    repeat (3) send_instr($urandom & 32'hFFFF_FFA0, 0, 0, 0);
    wait_idle();
    check("b2b_run", max_run, 3);
    check("b2b_count", instr_count, 3);

    send_instr(32'hAFBB_DCE0, 32'h0000_0062, 32'h0, 0);
    @(negedge clk);
    check("t1_valid", out_valid, 1'b1);
    check("t1_major", MajorOpcode, 4'b1010);
    check("t1_src1", Source1, 5'b11111);
    check("t1_src2", Source2, 5'b01110);
    check("t1_scale", OffsetScale, 2'b11);
    check("t1_dest", Destination, 5'b11011);
    check("t1_minor", MinorOpcode, 4'b1001);
    check("t1_hasaddr", HasAddress, 1'b1);
    check("t1_offsub", OffsetSub, 1'b1);
    check("t1_addr", Address, 98);
    wait_idle();

    // Stalled output slot must refuse the second word until the stall lifts.
    stall = 1'b1;
    send_instr(32'h1234_5620, 0, 0, 0);
    word_in = 32'h8765_4300;
    word_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_ready_low", word_ready, 1'b0);
      check("t3_valid_held", out_valid, 1'b1);
    end
    @(posedge clk);
    #2 stall = 1'b0;
    send_instr(32'h8765_4300, 0, 0, 0);
    wait_idle();
    check("t3_count", instr_count, 6);

    // Reset between ADDR_LO and ADDR_HI discards the partial instruction.
    send_word(32'hAFBB_DCE0, 0);
    send_word(32'h0000_0062, 0);
    do_reset();
    send_instr(32'hAFBB_DCA0, 0, 0, 0);
    @(negedge clk);
    check("t4_valid", out_valid, 1'b1);
    check("t4_hasaddr", HasAddress, 1'b0);
    check("t4_addr", Address, 0);
    wait_idle();

    // 17 deliveries since reset on a 4-bit counter wrap to 1.
    repeat (16) send_instr($urandom & 32'hFFFF_FFE0, $urandom, $urandom & 32'h0000_FFFF, 0);
    wait_idle();
    check("t6_count_wrap", instr_count, 1);

    send_instr(32'hAFBB_DCA1, 0, 0, 0);
    @(negedge clk);
`ifdef ILLEGAL_CHECK_EN
    check("t5_err", err, 1'b1);
    check("t5_valid", out_valid, 1'b0);
`else
    check("t5_err", err, 1'b0);
    check("t5_valid", out_valid, 1'b1);
`endif
    wait_idle();

    stall_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] hi;
      hi = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFF);
      send_instr($urandom, $urandom, hi, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
    wait_idle();
    stall_rand = 1'b0;
    @(posedge clk);
    #2 stall = 1'b0;
    check("err_pulses", err_seen, err_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
